dffr_shift_bank: RTL
====================

// Module: dffr_shift_bank
// PURPOSE
//   Parametrised successor to the single-bit DFF cell: a WIDTH-bit, DEPTH-stage
//   register bank built from edge-triggered stages with enable, parallel load and
//   synchronous active-high reset. It tracks fill level and flags when the output
//   stage holds written data. It serves as the sequential test vehicle for path and
//   timing-check verification alongside the combinational cells.
// PARAMETERS
//   WIDTH   8     bits per stage (>=1)
//   DEPTH   4     number of stages (>=2)
//   TCQ_R   0.13  ns, clock-to-output rise delay (used only with CMOS_SPECIFY_EN)
//   TCQ_F   0.15  ns, clock-to-output fall delay (used only with CMOS_SPECIFY_EN)
//   TSU     0.05  ns, D/PD/EN/LOAD setup to posedge C (CMOS_SPECIFY_EN only)
//   THD     0.02  ns, hold after posedge C (CMOS_SPECIFY_EN only)
// PORTS
//   C     in   1              clock; all state changes on posedge C
//   R     in   1              reset; synchronous, active-high
//   EN    in   1              shift enable
//   LOAD  in   1              parallel load strobe
//   D     in   WIDTH          serial input, written into stage 0 on shift
//   PD    in   WIDTH*DEPTH    parallel load data; stage i = PD[i*WIDTH +: WIDTH]
//   Q     out  WIDTH          stage DEPTH-1 (bank output)
//   PQ    out  WIDTH*DEPTH    all stages, same packing as PD
//   CNT   out  $clog2(DEPTH+1) number of stages holding written data
//   FULL  out  1              CNT == DEPTH
// BEHAVIOUR
//   - Priority at each posedge C: R > LOAD > EN > hold.
//   - R=1: every stage <= 0, CNT <= 0, FULL <= 0. This applies regardless of EN or
//     LOAD, including mid-operation. There is no asynchronous path; Q, PQ, CNT and
//     FULL are X only until the first edge with R=1.
//   - LOAD=1: stage i <= PD slice i for all i, CNT <= DEPTH. EN is ignored.
//   - EN=1, LOAD=0: stage 0 <= D, stage i <= stage i-1. CNT <= min(CNT+1, DEPTH),
//     saturating with no wrap. The old stage DEPTH-1 value is discarded.
//   - EN=0, LOAD=0: all state holds.
//   - Outputs are registered (no combinational input-to-output path).
//     FULL is derived from CNT, but reads as registered because CNT is registered.
//   - Latency: D sampled at enabled edge k appears on Q after edge k+DEPTH-1.
//     That is DEPTH enabled edges in total.
//   - Hold cycles (EN=0) do not advance the latency count.
//   - FULL rises on the same edge CNT reaches DEPTH and stays high until R=1.
//     Shifting while FULL keeps CNT=DEPTH.
//   - LOAD and EN both high for one edge behaves exactly as LOAD alone.
// CONFIGURATION
//   - CMOS_SPECIFY_EN defined: the module contains a specify block with:
//       * (posedge C *> Q)=(TCQ_R,TCQ_F), and likewise for PQ, CNT and FULL;
//       * $setup/$hold checks with TSU/THD for D, PD, EN, LOAD and R against
//         posedge C;
//       * a violation toggles a notifier that forces all stages to X until the
//         next edge with R=1.
//   - CMOS_SPECIFY_EN undefined: zero-delay, no timing checks, no notifier.
//   - Cycle-level function is identical in both builds.
// STRUCTURE
//   - Package cmos_cells_pkg: the mode encoding
//     typedef enum {M_HOLD, M_SHIFT, M_LOAD, M_RESET}. Also holds the default
//     delay constants (0.13/0.15/0.05/0.02) that parameters default from.
//   - Sub-module dffr_stage: one WIDTH-bit stage with inputs C, R, mode, shift-in,
//     load-in and output Q. It is instantiated DEPTH times in a generate loop.
//   - The counter and FULL logic sit in the top level.
// TESTING
//   1. R=1 for 1 edge with EN=LOAD=1, PD=all 1s -> PQ=0, CNT=0, FULL=0.
//   2. WIDTH=8, DEPTH=4, EN=1, D=0x11,0x22,0x33,0x44 ->
//      Q=0x11 after 4th edge, CNT=1,2,3,4, FULL=1 on edge 4.
//   3. From FULL, EN=1, D=0x55 -> Q=0x22, CNT stays 4 (saturation).
//      Then EN=0 for 3 edges -> PQ unchanged.
//   4. LOAD=1 and EN=1 together, PD=0xDDCCBBAA, D=0xFF -> PQ=0xDDCCBBAA,
//      Q=0xDD, CNT=4; D is ignored.
//   5. Mid-shift (CNT=2), R=1 together with EN=1 -> next edge PQ=0, CNT=0.
//      Following EN=1, D=0x77 -> stage 0 = 0x77, CNT=1.
//   6. CMOS_SPECIFY_EN defined, D changes 0.01 ns before posedge C ->
//      setup violation reported, PQ=X. Subsequent R=1 edge restores PQ=0.
//      Without the macro -> no report, clean value.

Source files
------------

// File: rtl/dffr_shift_bank_pkg.sv
//============================================================================
// Module      : cmos_cells_pkg
// Description : Shared mode encoding and default timing constants for the
//               dffr_shift_bank register bank and its stage cells.
//               Timing constants are only consumed when CMOS_SPECIFY_EN is
//               defined.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

package cmos_cells_pkg;

    // Per-edge operation applied to every stage, already priority-resolved
    typedef enum logic [1:0] {
        M_HOLD  = 2'd0,
        M_SHIFT = 2'd1,
        M_LOAD  = 2'd2,
        M_RESET = 2'd3
    } mode_e;

    // Default delays in ns
    localparam real C_TCQ_R = 0.13;
    localparam real C_TCQ_F = 0.15;
    localparam real C_TSU   = 0.05;
    localparam real C_THD   = 0.02;

endpackage

`default_nettype wire

// File: rtl/dffr_shift_bank_if.sv
//============================================================================
// Module      : dffr_shift_bank_if
// Description : Control, data and status bundle of the dffr_shift_bank
//               register bank. The master drives controls and data, the
//               slave (the bank) returns the stage contents and fill status.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

interface dffr_shift_bank_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int C_CNT_W = $clog2(DEPTH + 1);

    logic                     en;
    logic                     load;
    logic [WIDTH-1:0]         d;
    logic [WIDTH*DEPTH-1:0]   pd;
    logic [WIDTH-1:0]         q;
    logic [WIDTH*DEPTH-1:0]   pq;
    logic [C_CNT_W-1:0]       cnt;
    logic                     full;

    modport master (
        output en, load, d, pd,
        input  q, pq, cnt, full
    );

    modport slave (
        input  en, load, d, pd,
        output q, pq, cnt, full
    );

endinterface

`default_nettype wire

// File: rtl/dffr_shift_bank_stage.sv
//============================================================================
// Module      : dffr_stage
// Description : One WIDTH-bit edge-triggered stage of the shift bank. The
//               pre-resolved mode selects reset, parallel load, shift-in or
//               hold. With CMOS_SPECIFY_EN defined the cell carries
//               clock-to-output paths and setup/hold checks; a violation
//               corrupts the stage to X until the next edge with R=1.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module dffr_stage
    import cmos_cells_pkg::*;
#(
    parameter int  WIDTH = 8,
    parameter real TCQ_R = C_TCQ_R,
    parameter real TCQ_F = C_TCQ_F,
    parameter real TSU   = C_TSU,
    parameter real THD   = C_THD
) (
    input  wire logic             C,
    input  wire logic             R,
    input  wire mode_e            mode,
    input  wire logic [WIDTH-1:0] shift_in,
    input  wire logic [WIDTH-1:0] load_in,
    output logic      [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] r_q;

    // Stage register; R is checked directly so a reset never depends on mode
    always_ff @(posedge C) begin
        if (R) begin
            r_q <= '0;
        end else begin
            case (mode)
                M_RESET: r_q <= '0;
                M_LOAD:  r_q <= load_in;
                M_SHIFT: r_q <= shift_in;
                default: r_q <= r_q;
            endcase
        end
    end

`ifdef CMOS_SPECIFY_EN
    reg   notifier;
    logic r_notifier_seen;

    // Remember the notifier state at each reset edge; any later toggle
    // means a timing violation occurred and the contents are unknown.
    always_ff @(posedge C) begin
        if (R) begin
            r_notifier_seen <= notifier;
        end
    end

    assign Q = (notifier !== r_notifier_seen) ? {WIDTH{1'bx}} : r_q;

    specify
        (posedge C *> Q) = (TCQ_R, TCQ_F);
        $setup(shift_in, posedge C, TSU, notifier);
        $hold (posedge C, shift_in, THD, notifier);
        $setup(load_in,  posedge C, TSU, notifier);
        $hold (posedge C, load_in,  THD, notifier);
        $setup(mode,     posedge C, TSU, notifier);
        $hold (posedge C, mode,     THD, notifier);
        $setup(R,        posedge C, TSU, notifier);
        $hold (posedge C, R,        THD, notifier);
    endspecify
`else
    assign Q = r_q;
`endif

endmodule

`default_nettype wire

// File: rtl/dffr_shift_bank.sv
//============================================================================
// Module      : dffr_shift_bank
// Description : WIDTH-bit, DEPTH-stage register bank with shift enable,
//               parallel load and synchronous active-high reset. Tracks the
//               number of stages holding written data (saturating at DEPTH)
//               and flags FULL. Priority per edge: R > LOAD > EN > hold.
//               Optional macro CMOS_SPECIFY_EN adds path delays and timing
//               checks; cycle-level behaviour is the same in both builds.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module dffr_shift_bank
    import cmos_cells_pkg::*;
#(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 4,
    parameter real TCQ_R = C_TCQ_R,
    parameter real TCQ_F = C_TCQ_F,
    parameter real TSU   = C_TSU,
    parameter real THD   = C_THD
) (
    input wire logic           C,
    input wire logic           R,
    dffr_shift_bank_if.slave   bus
);

    localparam int               C_CNT_W = $clog2(DEPTH + 1);
    localparam logic [C_CNT_W-1:0] C_FULL_CNT = C_CNT_W'(DEPTH);

    mode_e              w_mode;
    logic [WIDTH-1:0]   w_stage_q [DEPTH];
    logic [C_CNT_W-1:0] r_cnt;
    logic               w_full;

    // Resolve the per-edge operation once for all stages
    always_comb begin
        w_mode = M_HOLD;
        if (R) begin
            w_mode = M_RESET;
        end else if (bus.load) begin
            w_mode = M_LOAD;
        end else if (bus.en) begin
            w_mode = M_SHIFT;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] w_shift_in;

        if (i == 0) begin : g_head
            assign w_shift_in = bus.d;
        end else begin : g_tail
            assign w_shift_in = w_stage_q[i-1];
        end

        dffr_stage #(
            .WIDTH (WIDTH),
            .TCQ_R (TCQ_R),
            .TCQ_F (TCQ_F),
            .TSU   (TSU),
            .THD   (THD)
        ) u_stage (
            .C        (C),
            .R        (R),
            .mode     (w_mode),
            .shift_in (w_shift_in),
            .load_in  (bus.pd[i*WIDTH +: WIDTH]),
            .Q        (w_stage_q[i])
        );

        assign bus.pq[i*WIDTH +: WIDTH] = w_stage_q[i];
    end

    assign bus.q = w_stage_q[DEPTH-1];

    // Fill-level counter: load fills the bank, shifts saturate at DEPTH
    always_ff @(posedge C) begin
        if (R) begin
            r_cnt <= '0;
        end else if (bus.load) begin
            r_cnt <= C_FULL_CNT;
        end else if (bus.en && (r_cnt != C_FULL_CNT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Decoded from the registered count, so it behaves as a registered flag
    assign w_full = (r_cnt == C_FULL_CNT);

`ifdef CMOS_SPECIFY_EN
    assign #(TCQ_R, TCQ_F) bus.cnt  = r_cnt;
    assign #(TCQ_R, TCQ_F) bus.full = w_full;
`else
    assign bus.cnt  = r_cnt;
    assign bus.full = w_full;
`endif

endmodule

`default_nettype wire
